// File: rtl/seq_cnt_pkg.sv
// Shared constants and helpers for the arbitrary-sequence counter.
package seq_cnt_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // 0000->1101->1011->1001->0110->1100->0011->1111, entry 0 in the LSBs.
  localparam logic [31:0] SEQ_DEFAULT = 32'hF3C69BD0;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_cnt_match.sv
// Combinational LENGTH-way lookup of a code in the sequence table.
module seq_cnt_match
  import seq_cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LENGTH = 8,
  parameter logic [LENGTH*WIDTH-1:0] SEQ = SEQ_DEFAULT
) (
  input  logic [WIDTH-1:0]         code,
  output logic                     hit,
  output logic [idx_w(LENGTH)-1:0] index
);

  localparam int unsigned IW = idx_w(LENGTH);

  // Entries are distinct, so at most one compare fires.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (SEQ[i*WIDTH +: WIDTH] == code) begin
        hit   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/seq_cnt.sv
// Arbitrary-sequence counter with load, wrap pulse and illegal-state recovery.
// Define SEQ_CNT_ILLEGAL_ERR_EN to build the sticky err flag and port.
module seq_cnt
  import seq_cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LENGTH = 8,
  parameter logic [LENGTH*WIDTH-1:0] SEQ = SEQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     dir,
  input  logic                     ld,
  input  logic [WIDTH-1:0]         ld_val,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         q,
  output logic [idx_w(LENGTH)-1:0] idx,
  output logic                     legal,
  output logic                     wrap
`ifdef SEQ_CNT_ILLEGAL_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int unsigned      IW   = idx_w(LENGTH);
  localparam logic [WIDTH-1:0] SEQ0 = SEQ[WIDTH-1:0];
  localparam logic [IW-1:0]    LAST = IW'(LENGTH - 1);

  logic            q_hit, ld_hit;
  logic [IW-1:0]   q_index, ld_index, nxt_index;
  logic [WIDTH-1:0] nxt_code;
  logic            nxt_wrap;
  logic            ill_evt;

  seq_cnt_match #(.WIDTH(WIDTH), .LENGTH(LENGTH), .SEQ(SEQ)) u_match_q (
    .code  (q),
    .hit   (q_hit),
    .index (q_index)
  );

  seq_cnt_match #(.WIDTH(WIDTH), .LENGTH(LENGTH), .SEQ(SEQ)) u_match_ld (
    .code  (ld_val),
    .hit   (ld_hit),
    .index (ld_index)
  );

  assign legal   = q_hit;
  assign ill_evt = !ld && en && !q_hit;

  always_comb begin
    nxt_wrap = 1'b0;
    if (dir == DIR_FWD) begin
      if (q_index == LAST) begin
        nxt_index = '0;
        nxt_wrap  = 1'b1;
      end else begin
        nxt_index = q_index + 1'b1;
      end
    end else begin
      if (q_index == '0) begin
        nxt_index = LAST;
        nxt_wrap  = 1'b1;
      end else begin
        nxt_index = q_index - 1'b1;
      end
    end
    nxt_code = SEQ0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (nxt_index == IW'(i)) nxt_code = SEQ[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q    <= SEQ0;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (ld) begin
      q    <= ld_val;
      idx  <= ld_hit ? ld_index : '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (q_hit) begin
        q    <= nxt_code;
        idx  <= nxt_index;
        wrap <= nxt_wrap;
      end else begin
        // Unused code: force back onto the sequence regardless of dir.
        q    <= SEQ0;
        idx  <= '0;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef SEQ_CNT_ILLEGAL_ERR_EN
  // Set has priority over clr_err.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      err <= 1'b0;
    end else if (ill_evt) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clr_err ^ ill_evt;
`endif

endmodule

// File: tb/tb_seq_cnt.sv
// Randomized and directed bench for seq_cnt, checked against a table-driven model.
module tb_seq_cnt;

  typedef struct {
    int len;
    int seq[16];
    int q;
    int idx;
    bit wrap;
    bit err;
  } model_t;

  logic       clk = 1'b0;
  logic       clear, en, dir, ld, clr_err;
  logic [3:0] ld_val;

  logic [3:0] qa;
  logic [2:0] idxa;
  logic       legala, wrapa;
  logic [2:0] qb;
  logic [2:0] idxb;
  logic       legalb, wrapb;
`ifdef SEQ_CNT_ILLEGAL_ERR_EN
  logic       erra, errb;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  model_t ma, mb;

  always #5 clk = ~clk;

  seq_cnt u_dut_a (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .dir     (dir),
    .ld      (ld),
    .ld_val  (ld_val),
    .clr_err (clr_err),
    .q       (qa),
    .idx     (idxa),
    .legal   (legala),
`ifdef SEQ_CNT_ILLEGAL_ERR_EN
    .err     (erra),
`endif
    .wrap    (wrapa)
  );

  seq_cnt #(
    .WIDTH  (3),
    .LENGTH (5),
    .SEQ    ({3'd7, 3'd2, 3'd4, 3'd1, 3'd6})
  ) u_dut_b (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .dir     (dir),
    .ld      (ld),
    .ld_val  (ld_val[2:0]),
    .clr_err (clr_err),
    .q       (qb),
    .idx     (idxb),
    .legal   (legalb),
`ifdef SEQ_CNT_ILLEGAL_ERR_EN
    .err     (errb),
`endif
    .wrap    (wrapb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input model_t m, input int v);
    for (int i = 0; i < m.len; i++) if (m.seq[i] == v) return i;
    return -1;
  endfunction

  function automatic model_t mreset(input model_t m);
    model_t r = m;
    r.q = m.seq[0]; r.idx = 0; r.wrap = 0; r.err = 0;
    return r;
  endfunction

  function automatic model_t mstep(input model_t m, input bit l, input int lv, input bit e,
                                   input bit d, input bit ce);
    model_t r = m;
    int p = find(m, m.q);
    int n;
    if (l) begin
      r.q = lv;
      r.idx = (find(m, lv) < 0) ? 0 : find(m, lv);
      r.wrap = 0;
    end else if (e && p < 0) begin
      r.q = m.seq[0]; r.idx = 0; r.wrap = 0;
    end else if (e) begin
      n = d ? (p + m.len - 1) % m.len : (p + 1) % m.len;
      r.wrap = d ? (p == 0) : (p == m.len - 1);
      r.q = m.seq[n];
      r.idx = n;
    end else begin
      r.wrap = 0;
    end
    if (!l && e && p < 0) r.err = 1;
    else if (ce) r.err = 0;
    return r;
  endfunction

  task automatic check_all();
    check_eq("a.q", 32'(qa), ma.q);
    check_eq("a.idx", 32'(idxa), ma.idx);
    check_eq("a.wrap", 32'(wrapa), 32'(ma.wrap));
    check_eq("a.legal", 32'(legala), 32'(find(ma, ma.q) >= 0));
    check_eq("b.q", 32'(qb), mb.q);
    check_eq("b.idx", 32'(idxb), mb.idx);
    check_eq("b.wrap", 32'(wrapb), 32'(mb.wrap));
    check_eq("b.legal", 32'(legalb), 32'(find(mb, mb.q) >= 0));
`ifdef SEQ_CNT_ILLEGAL_ERR_EN
    check_eq("a.err", 32'(erra), 32'(ma.err));
    check_eq("b.err", 32'(errb), 32'(mb.err));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = mstep(ma, ld, int'(ld_val), en, dir, clr_err);
    mb = mstep(mb, ld, int'(ld_val[2:0]), en, dir, clr_err);
    #1;
    check_all();
  endtask

  initial begin
    int sa[8]   = '{0, 13, 11, 9, 6, 12, 3, 15};
    int sb[5]   = '{6, 1, 4, 2, 7};
    int fwd_a[8] = '{13, 11, 9, 6, 12, 3, 15, 0};
    int fwd_b[8] = '{1, 4, 2, 7, 6, 1, 4, 2};

    ma.len = 8;
    mb.len = 5;
    for (int i = 0; i < 16; i++) begin
      ma.seq[i] = (i < 8) ? sa[i] : -1;
      mb.seq[i] = (i < 5) ? sb[i] : -1;
    end
    ma = mreset(ma);
    mb = mreset(mb);

    clear = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; ld_val = '0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    clear = 1'b0;

    // Forward through the whole table and back to entry 0.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("fwd_a.q", 32'(qa), fwd_a[i]);
      check_eq("fwd_a.wrap", 32'(wrapa), 32'(i == 7));
      check_eq("fwd_b.q", 32'(qb), fwd_b[i]);
      check_eq("fwd_b.wrap", 32'(wrapb), 32'(i == 4));
    end

    // Reverse wrap from 0 to F, then F to 3.
    dir = 1'b1;
    cycle();
    check_eq("rev.q0", 32'(qa), 32'hF);
    check_eq("rev.wrap0", 32'(wrapa), 32'd1);
    cycle();
    check_eq("rev.q1", 32'(qa), 32'h3);
    check_eq("rev.idx1", 32'(idxa), 32'd6);

    // Load beats enable; next step continues from the loaded entry.
    dir = 1'b0; ld = 1'b1; ld_val = 4'h6;
    cycle();
    check_eq("ld.idx", 32'(idxa), 32'd4);
    ld = 1'b0;
    cycle();
    check_eq("ld.step", 32'(qa), 32'hC);

    // Illegal load (5 is unused in both tables), hold, then recover.
    ld = 1'b1; ld_val = 4'h5; en = 1'b0;
    cycle();
    check_eq("ill.legal", 32'(legala), 32'd0);
    ld = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    check_eq("ill.recover", 32'(qa), 32'h0);
    en = 1'b0;
    cycle();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // ld_val=3 is unused in the 3-bit table; one step returns it to 6.
    ld = 1'b1; ld_val = 4'h3;
    cycle();
    ld = 1'b0; en = 1'b1;
    cycle();
    check_eq("b.recover", 32'(qb), 32'd6);

    // Asynchronous clear between edges with q at 9.
    ld = 1'b1; ld_val = 4'h0;
    cycle();
    ld = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("pre_clear.q", 32'(qa), 32'h9);
    en = 1'b0;
    #2 clear = 1'b1;
    #1;
    ma = mreset(ma);
    mb = mreset(mb);
    check_eq("aclr.q", 32'(qa), 32'h0);
    check_eq("aclr.idx", 32'(idxa), 32'd0);
    check_all();
    #1 clear = 1'b0;
    en = 1'b1;
    cycle();
    check_eq("post_clear.q", 32'(qa), 32'hD);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ld      = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom_range(0, 1));
      ld_val  = 4'($urandom_range(0, 15));
      clr_err = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
